// File: rtl/opl3_axi_regbank.sv
// AXI4-Lite register bank for the OPL3 core: NUM_RW control registers with byte strobes
// and write pulses, followed by NUM_RO status registers sampled when they are read.
module opl3_axi_regbank #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    NUM_RW      = 8,
    parameter int                    NUM_RO      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
    input  logic [2:0]                   s_axi_awprot,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [2:0]                   s_axi_arprot,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_out,
    output logic [NUM_RW-1:0]            wr_pulse,
    input  logic [NUM_RO*DATA_WIDTH-1:0] status_in
);
    localparam int         STRB_W = DATA_WIDTH / 8;
    localparam int         LSB    = $clog2(STRB_W);
    localparam int         IDX_W  = ADDR_WIDTH - LSB;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Handshakes: a beat transfers on a rising edge where valid && ready; a source holds
    // its payload stable while valid && !ready, and ready never depends on valid.
    logic                  aw_full_q, aw_full_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_RW-1:0]     wr_pulse_q, wr_pulse_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_RW];
    logic [DATA_WIDTH-1:0] regs_d [NUM_RW];

    logic                  commit, ar_hs;
    logic [31:0]           aw_idx_ext, ar_idx_ext;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [1:0]            rd_resp_mux;
    logic                  unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

    assign s_axi_awready = ~aw_full_q;
    assign s_axi_wready  = ~w_full_q;
    assign s_axi_arready = ~rvalid_q | s_axi_rready;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

    assign commit     = aw_full_q & w_full_q & (~bvalid_q | s_axi_bready);
    assign ar_hs      = s_axi_arvalid & s_axi_arready;
    assign aw_idx_ext = 32'(aw_idx_q);
    assign ar_idx_ext = 32'(s_axi_araddr[ADDR_WIDTH-1:LSB]);

    always_comb begin
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (aw_idx_ext < 32'(NUM_RW)) ? OKAY : SLVERR;
        end else if (s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (s_axi_awvalid && !aw_full_q) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi_awaddr[ADDR_WIDTH-1:LSB];
        end
        if (s_axi_wvalid && !w_full_q) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end

        // Out-of-range and RO indices match no k here, so they change nothing.
        for (int k = 0; k < NUM_RW; k++) begin
            if (commit && aw_idx_ext == 32'(k)) begin
                wr_pulse_d[k] = 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                    if (w_strb_q[b]) regs_d[k][b*8 +: 8] = w_data_q[b*8 +: 8];
                end
            end
        end
    end

    // Reads see regs_q, so a write committing on the same edge is not yet visible.
    always_comb begin
        rd_mux      = '0;
        rd_resp_mux = SLVERR;
        for (int k = 0; k < NUM_RW; k++) begin
            if (ar_idx_ext == 32'(k)) begin
                rd_mux      = regs_q[k];
                rd_resp_mux = OKAY;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (ar_idx_ext == 32'(NUM_RW + j)) begin
                rd_mux      = status_in[j*DATA_WIDTH +: DATA_WIDTH];
                rd_resp_mux = OKAY;
            end
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
            rresp_d  = rd_resp_mux;
        end else if (s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            for (int k = 0; k < NUM_RW; k++) regs_q[k] <= RESET_VALUE;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            for (int k = 0; k < NUM_RW; k++) regs_q[k] <= regs_d[k];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RW; g++) begin : g_ctrl
            assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
        end
    endgenerate
endmodule

// File: tb/tb_opl3_axi_regbank.sv
// Randomised bench for opl3_axi_regbank against an array-based register-map model with
// directed cases for strobes, channel ordering, B backpressure, RO writes and mid-write reset.
module tb_opl3_axi_regbank;
    localparam int NRW = 8;
    localparam int NRO = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [5:0]   s_axi_awaddr, s_axi_araddr;
    logic [2:0]   s_axi_awprot, s_axi_arprot;
    logic         s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0]  s_axi_wdata, s_axi_rdata;
    logic [3:0]   s_axi_wstrb;
    logic [1:0]   s_axi_bresp, s_axi_rresp;
    logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic         s_axi_rvalid, s_axi_rready;
    logic [255:0] ctrl_out;
    logic [7:0]   wr_pulse;
    logic [127:0] status_in;

    logic [31:0]  m_reg [NRW];
    int           exp_pulse [NRW];
    int           seen_pulse [NRW];
    logic [31:0]  exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    opl3_axi_regbank dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .ctrl_out(ctrl_out), .wr_pulse(wr_pulse), .status_in(status_in)
    );

    always @(negedge clk) begin
        for (int k = 0; k < NRW; k++) if (wr_pulse[k]) seen_pulse[k]++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [5:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        int idx;
        logic [31:0] mask;
        idx  = int'(addr) / 4;
        mask = '0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
        if (idx < NRW) begin
            m_reg[idx] = (m_reg[idx] & ~mask) | (data & mask);
            exp_pulse[idx]++;
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [5:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        if (idx < NRW) begin
            data = m_reg[idx];
            resp = 2'b00;
        end else if (idx < NRW + NRO) begin
            data = status_in[(idx - NRW) * 32 +: 32];
            resp = 2'b00;
        end else begin
            data = '0;
            resp = 2'b10;
        end
    endtask

    task automatic check_ctrl(input string tag);
        for (int k = 0; k < NRW; k++) check_val(tag, ctrl_out[k*32 +: 32], m_reg[k]);
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int bdly);
        logic aw_done, w_done, aw_s, w_s;
        logic [1:0] exp_resp;
        int cyc;
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_s = s_axi_awready;
            w_s  = s_axi_wready;
            step();
            cyc++;
            if (s_axi_awvalid && aw_s) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
            if (s_axi_wvalid && w_s) begin w_done = 1'b1; s_axi_wvalid = 1'b0; end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check_val("wr_accept", {aw_done, w_done}, 2'b11);
        cyc = 0;
        while (!s_axi_bvalid && cyc < 20) begin step(); cyc++; end
        check_val("bvalid_seen", s_axi_bvalid, 1'b1);
        for (int i = 0; i < bdly; i++) begin
            step();
            check_val("bvalid_hold", s_axi_bvalid, 1'b1);
        end
        model_write(addr, data, strb, exp_resp);
        check_val("bresp", s_axi_bresp, exp_resp);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        check_val("bvalid_clear", s_axi_bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [5:0] addr, input int rdly);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        logic        got, ar_s;
        int          cyc;
        model_read(addr, exp_d, exp_r);
        exp_q.push_back(exp_d);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 20) begin
            ar_s = s_axi_arready;
            step();
            cyc++;
            if (ar_s) got = 1'b1;
        end
        s_axi_arvalid = 1'b0;
        check_val("rd_latency", {got, s_axi_rvalid}, 2'b11);
        for (int i = 0; i < rdly; i++) step();
        check_val("rdata", s_axi_rdata, exp_q.pop_front());
        check_val("rresp", s_axi_rresp, exp_r);
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        check_val("rvalid_clear", s_axi_rvalid, 1'b0);
    endtask

    task automatic check_pulses(input string tag);
        for (int k = 0; k < NRW; k++) check_val(tag, seen_pulse[k], exp_pulse[k]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] da, db, dz;
        logic [1:0]  r;
        int          psum;

        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        status_in = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < NRW; k++) m_reg[k] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check_val("rst_awready", s_axi_awready, 1'b1);
        check_val("rst_wready", s_axi_wready, 1'b1);
        check_val("rst_arready", s_axi_arready, 1'b1);
        check_val("rst_bvalid", s_axi_bvalid, 1'b0);
        check_val("rst_rvalid", s_axi_rvalid, 1'b0);
        check_val("rst_rdata", s_axi_rdata, 32'h0);
        check_val("rst_pulse", wr_pulse, 8'h0);
        check_ctrl("rst_ctrl");

        for (int i = 0; i < 16; i++) do_read(6'(i * 4), 0);

        for (int i = 0; i < NRW; i++) do_write(6'(i * 4), 32'(i + 1), 4'hF, 0);
        for (int i = 0; i < NRW; i++) do_read(6'(i * 4), i % 2);
        check_pulses("pulse_seq");

        do_write(6'h08, 32'hAABBCCDD, 4'hF, 0);
        do_write(6'h08, 32'h11223344, 4'b0101, 2);
        do_read(6'h08, 0);
        check_val("strb_merge", ctrl_out[2*32 +: 32], 32'hAA22CC44);

        // W leads AW by three cycles, then a second write waits behind an undrained B.
        da = $urandom; db = $urandom;
        s_axi_wdata = da; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        step();
        s_axi_wvalid = 1'b0;
        check_val("w_only_wready", s_axi_wready, 1'b0);
        step(); step();
        check_val("w_only_no_b", s_axi_bvalid, 1'b0);
        s_axi_awaddr = 6'h0C; s_axi_awvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        check_val("w_first_no_b_yet", s_axi_bvalid, 1'b0);
        step();
        model_write(6'h0C, da, 4'hF, r);
        check_val("w_first_bvalid", s_axi_bvalid, 1'b1);
        check_val("w_first_bresp", s_axi_bresp, r);
        check_val("w_first_pulse", wr_pulse, 8'h08);
        check_ctrl("w_first_ctrl");
        s_axi_awaddr = 6'h10; s_axi_wdata = db; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_bvalid", s_axi_bvalid, 1'b1);
            check_val("bp_ready", {s_axi_awready, s_axi_wready}, 2'b00);
            check_val("bp_reg4", ctrl_out[4*32 +: 32], m_reg[4]);
            step();
        end
        s_axi_bready = 1'b1;
        step();
        model_write(6'h10, db, 4'hF, r);
        check_val("bp_second_bvalid", s_axi_bvalid, 1'b1);
        check_val("bp_second_pulse", wr_pulse, 8'h10);
        check_ctrl("bp_second_ctrl");
        step();
        s_axi_bready = 1'b0;
        check_val("bp_drained", s_axi_bvalid, 1'b0);

        psum = 0;
        for (int k = 0; k < NRW; k++) psum += seen_pulse[k];
        do_write(6'h20, 32'hFFFFFFFF, 4'hF, 0);
        step();
        for (int k = 0; k < NRW; k++) psum -= seen_pulse[k];
        check_val("ro_no_pulse", 32'(psum), 32'h0);
        do_read(6'h20, 0);

        // Read and write of the same register on one edge: read sees the old value.
        do_write(6'h18, $urandom, 4'hF, 0);
        da = m_reg[6];
        db = $urandom;
        s_axi_awaddr = 6'h18; s_axi_wdata = db; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = 6'h18; s_axi_arvalid = 1'b1;
        step();
        s_axi_arvalid = 1'b0;
        model_write(6'h18, db, 4'hF, r);
        check_val("rw_same_rvalid", s_axi_rvalid, 1'b1);
        check_val("rw_same_old", s_axi_rdata, da);
        check_val("rw_same_bvalid", s_axi_bvalid, 1'b1);
        check_ctrl("rw_same_ctrl");
        step();
        check_val("rdata_stable", s_axi_rdata, da);
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        step();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        check_val("rw_same_drain", {s_axi_bvalid, s_axi_rvalid}, 2'b00);

        // Reset with only AW captured: the address must be discarded.
        s_axi_awaddr = 6'h14; s_axi_awvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        check_val("mid_aw_held", s_axi_awready, 1'b0);
        reset = 1'b1;
        #2;
        check_val("async_rst_awready", s_axi_awready, 1'b1);
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < NRW; k++) m_reg[k] = '0;
        check_val("post_rst_awready", s_axi_awready, 1'b1);
        check_val("post_rst_bvalid", s_axi_bvalid, 1'b0);
        check_ctrl("post_rst_ctrl");
        dz = $urandom;
        s_axi_wdata = dz; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        step();
        s_axi_wvalid = 1'b0;
        step(); step(); step();
        check_val("stale_aw_no_b", s_axi_bvalid, 1'b0);
        s_axi_awaddr = 6'h14; s_axi_awvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        step();
        model_write(6'h14, dz, 4'hF, r);
        check_val("post_rst_bvalid2", s_axi_bvalid, 1'b1);
        check_val("post_rst_bresp", s_axi_bresp, r);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        check_ctrl("post_rst_ctrl2");

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) < 2) begin
                do_write(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3));
            end else begin
                status_in = {$urandom, $urandom, $urandom, $urandom};
                do_read(6'($urandom_range(0, 63)), $urandom_range(0, 2));
            end
        end
        step();
        check_ctrl("final_ctrl");
        check_pulses("final_pulse");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
